// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch slice: FSM states and the FIFO entry.
// No logic, so there is no latency to describe.
// Carries no handshake, so there is no backpressure to describe.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundles the fetch unit's memory, control and decode-facing signals.
// Wires only, so there is no latency of its own.
// Decode backpressures through out_ready; the memory offers no backpressure.
interface instr_fetch_unit_if;
    import fetch_pkg::*;

    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_rd_en;
    logic [INSTR_W-1:0] imem_instr;
    logic               imem_ready;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               halt_req;
    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic               out_ready;
    logic               halted;

    modport master (
        output imem_addr, imem_rd_en,
        input  imem_instr, imem_ready,
        input  redirect_valid, redirect_pc, halt_req,
        output out_valid, out_instr, out_pc,
        input  out_ready,
        output halted
    );

    modport slave (
        input  imem_addr, imem_rd_en,
        output imem_instr, imem_ready,
        output redirect_valid, redirect_pc, halt_req,
        input  out_valid, out_instr, out_pc,
        output out_ready,
        input  halted
    );

endinterface

// File: rtl/fetch_fifo.sv
// Show-ahead FIFO with synchronous flush; the head is visible combinationally.
// Latency: a push shows up on dout the cycle after it is written.
// Backpressure: a push when full is dropped unless a pop frees a slot that cycle.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & ((count < DEPTH_C) | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: issues word reads at pc and queues {pc, instr} for decode.
// Latency: issue in N, push in N+1, out_valid in N+2; one instruction per cycle sustained.
// Backpressure: issue stalls when the FIFO plus the outstanding read would exceed DEPTH.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [31:0] PC_INC   = 32'd1,
    parameter int          DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    instr_fetch_unit_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pend_pc;
    logic              inflight;

    logic [CW-1:0]     count;
    logic              empty;
    logic              pop;
    logic              push;
    logic              issue;
    logic              space;
    logic [CW:0]       occ;
    fetch_entry_t      head;
    fetch_entry_t      push_entry;

    assign pop = ~empty & bus.out_ready;

    // Occupancy once the outstanding read lands, net of this cycle's pop.
    assign occ   = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    assign space = (occ < DEPTH_C);
    assign issue = (state == RUN) & ~bus.halt_req & ~bus.redirect_valid & space;

    // A response with no read outstanding is a protocol error and is dropped.
    assign push             = bus.imem_ready & inflight & ~bus.redirect_valid;
    assign push_entry.pc    = pend_pc;
    assign push_entry.instr = bus.imem_instr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            pend_pc  <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pend_pc <= pc;
            end
            if (bus.redirect_valid) begin
                pc <= bus.redirect_pc;
            end else if (issue) begin
                pc <= pc + PC_INC;
            end
            case (state)
                BOOT:    state <= RUN;
                RUN:     if (bus.halt_req)  state <= HALT;
                HALT:    if (!bus.halt_req) state <= RUN;
                default: state <= BOOT;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect_valid),
        .din   (push_entry),
        .dout  (head),
        .count (count),
        .empty (empty)
    );

    assign bus.imem_rd_en = issue;
    assign bus.imem_addr  = pc;
    assign bus.out_valid  = ~empty;
    assign bus.out_pc     = head.pc;
    assign bus.out_instr  = head.instr;
    assign bus.halted     = (state == HALT) & ~inflight;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: one instance at RESET_PC=0, one at RESET_PC=FFFFFFFF.
// Memory returns addr+0x1000 one cycle after each read.
module tb_instr_fetch_unit;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    int   n_issue;
    logic [31:0] log_q[$];

    instr_fetch_unit_if f();
    instr_fetch_unit_if g();

    instr_fetch_unit #(.RESET_PC(32'h0), .PC_INC(32'd1), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (f)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFF), .PC_INC(32'd1), .DEPTH(2)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (g)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        f.imem_ready <= f.imem_rd_en;
        f.imem_instr <= f.imem_addr + 32'h1000;
        g.imem_ready <= g.imem_rd_en;
        g.imem_instr <= g.imem_addr + 32'h1000;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (f.out_valid && f.out_ready) log_q.push_back(f.out_pc);
            if (f.imem_rd_en) n_issue++;
            if (f.imem_ready && !dut.inflight) begin
                n_cmp++;
                n_fail++;
                $error("FAIL protocol_ready: observed inflight=0 with imem_ready=1, expected inflight=1");
            end
            n_cmp++;
            assert (dut.u_fifo.count <= 2) else begin
                n_fail++;
                $error("FAIL fifo_count: observed %0d expected <=2", dut.u_fifo.count);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; n_issue = 0;
        rst = 1'b1;
        f.halt_req = 1'b0; f.redirect_valid = 1'b0; f.redirect_pc = '0; f.out_ready = 1'b1;
        g.halt_req = 1'b0; g.redirect_valid = 1'b0; g.redirect_pc = '0; g.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_en",     32'(f.imem_rd_en), 32'd0);
        chk("rst_out_valid", 32'(f.out_valid),  32'd0);
        chk("rst_out_pc",    f.out_pc,          32'd0);
        chk("rst_out_instr", f.out_instr,       32'd0);
        chk("rst_halted",    32'(f.halted),     32'd0);
        chk("rst_wrap_rd",   32'(g.imem_rd_en), 32'd0);

        // Boot, first fetch, streaming, wrap instance alongside.
        rst = 1'b0; log_q.delete(); n_issue = 0;
        #1;
        chk("boot_no_rd", 32'(f.imem_rd_en), 32'd0);
        tick(); #1;
        chk("a1_rd_en", 32'(f.imem_rd_en), 32'd1);
        chk("a1_addr",  f.imem_addr,       32'h0);
        chk("wrap_addr0", g.imem_addr,     32'hFFFF_FFFF);
        chk("wrap_rd0", 32'(g.imem_rd_en), 32'd1);
        tick(); #1;
        chk("a2_addr",  f.imem_addr,       32'h1);
        chk("a2_out_valid", 32'(f.out_valid), 32'd0);
        chk("wrap_addr1", g.imem_addr,     32'h0);
        tick(); #1;
        chk("a3_out_valid", 32'(f.out_valid), 32'd1);
        chk("a3_out_pc",    f.out_pc,         32'h0);
        chk("a3_out_instr", f.out_instr,      32'h1000);
        chk("a3_addr",      f.imem_addr,      32'h2);
        chk("wrap_out_pc0",    g.out_pc,      32'hFFFF_FFFF);
        chk("wrap_out_instr0", g.out_instr,   32'h0000_0FFF);
        tick(); #1;
        chk("a4_out_pc", f.out_pc,    32'h1);
        chk("a4_addr",   f.imem_addr, 32'h3);
        chk("wrap_out_pc1", g.out_pc, 32'h0);
        tick(); #1;
        chk("a5_out_pc", f.out_pc,    32'h2);
        chk("a5_rd_en",  32'(f.imem_rd_en), 32'd1);
        tick(); #1;
        chk("a6_out_pc", f.out_pc,    32'h3);
        chk("a6_addr",   f.imem_addr, 32'h5);

        // Redirect while the pc 5 response lands.
        tick();
        f.redirect_valid = 1'b1; f.redirect_pc = 32'h100;
        #1;
        chk("rd_resp_arrives", 32'(f.imem_ready), 32'd1);
        chk("rd_no_issue",     32'(f.imem_rd_en), 32'd0);
        chk("rd_pop_pc4",      f.out_pc,          32'h4);
        tick();
        f.redirect_valid = 1'b0;
        #1;
        chk("rd_flushed",  32'(f.out_valid),  32'd0);
        chk("rd_new_rd",   32'(f.imem_rd_en), 32'd1);
        chk("rd_new_addr", f.imem_addr,       32'h100);
        tick(); #1;
        chk("rd_gap", 32'(f.out_valid), 32'd0);
        tick(); #1;
        chk("rd_out_valid", 32'(f.out_valid), 32'd1);
        chk("rd_out_pc",    f.out_pc,         32'h100);
        chk("rd_out_instr", f.out_instr,      32'h1100);
        tick();
        chk("log_size_ge6", 32'(log_q.size() >= 6), 32'd1);
        for (int i = 0; i < 5; i++) chk("log_stream", log_q[i], 32'(i));
        chk("log_after_redirect", log_q[5], 32'h100);

        // Mid-stream reset drops outputs immediately.
        #1;
        chk("pre_rst_rd",    32'(f.imem_rd_en), 32'd1);
        chk("pre_rst_valid", 32'(f.out_valid),  32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_rd",    32'(f.imem_rd_en), 32'd0);
        chk("mid_rst_valid", 32'(f.out_valid),  32'd0);

        // Backpressure from the start: two fetches fill the FIFO, then stall.
        tick();
        f.out_ready = 1'b0;
        tick();
        rst = 1'b0; log_q.delete(); n_issue = 0;
        #1;
        chk("bp_boot", 32'(f.imem_rd_en), 32'd0);
        tick(); #1;
        chk("bp_addr0", f.imem_addr, 32'h0);
        tick(); #1;
        chk("bp_addr1", f.imem_addr, 32'h1);
        chk("bp_rd1", 32'(f.imem_rd_en), 32'd1);
        tick(); #1;
        chk("bp_stall3", 32'(f.imem_rd_en), 32'd0);
        chk("bp_head0",  f.out_pc, 32'h0);
        tick(); #1;
        chk("bp_stall4", 32'(f.imem_rd_en), 32'd0);
        tick(); #1;
        chk("bp_stall5",   32'(f.imem_rd_en), 32'd0);
        chk("bp_issues",   32'(n_issue),      32'd2);
        chk("bp_no_pops",  32'(log_q.size()), 32'd0);
        f.out_ready = 1'b1;
        #1;
        chk("bp_resume_rd",   32'(f.imem_rd_en), 32'd1);
        chk("bp_resume_addr", f.imem_addr,       32'h2);
        repeat (4) tick();
        chk("bp_log_size", 32'(log_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("bp_log_order", log_q[i], 32'(i));

        // Halt for five cycles, then resume at the next pc.
        rst = 1'b1;
        tick();
        rst = 1'b0; log_q.delete();
        repeat (4) tick();
        f.halt_req = 1'b1;
        #1;
        chk("halt_no_rd",     32'(f.imem_rd_en), 32'd0);
        chk("halt_not_yet",   32'(f.halted),     32'd0);
        for (int i = 1; i < 5; i++) begin
            tick(); #1;
            chk("halt_halted", 32'(f.halted),     32'd1);
            chk("halt_rd_off", 32'(f.imem_rd_en), 32'd0);
        end
        tick();
        f.halt_req = 1'b0;
        #1;
        chk("unhalt_still_off", 32'(f.imem_rd_en), 32'd0);
        tick(); #1;
        chk("unhalt_rd",     32'(f.imem_rd_en), 32'd1);
        chk("unhalt_addr",   f.imem_addr,       32'h3);
        chk("unhalt_halted", 32'(f.halted),     32'd0);
        repeat (2) tick();
        #1;
        chk("unhalt_out_valid", 32'(f.out_valid), 32'd1);
        chk("unhalt_out_pc",    f.out_pc,         32'h3);
        chk("halt_log_size",    32'(log_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) chk("halt_log_order", log_q[i], 32'(i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
